// File: rtl/aes_mode_ctrl_if.sv
// rtl/aes_mode_ctrl_if.sv - config, block stream and AES core signal bundle for aes_mode_ctrl
interface aes_mode_ctrl_if;
  logic [1:0]   cfg_mode_i;
  logic         cfg_decrypt_i;
  logic [127:0] cfg_iv_i;
  logic [127:0] key_i;
  logic         key_load_i;
  logic         msg_start_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] in_data_i;
  logic         in_last_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] out_data_o;
  logic         out_last_o;
  logic         busy_o;
  logic         cfg_err_o;
  logic         core_start_enc_o;
  logic         core_start_dec_o;
  logic         core_load_key_o;
  logic [127:0] core_data_o;
  logic [127:0] core_data_i;
  logic         core_ready_i;
  logic         core_done_i;

  modport slave (
    input  cfg_mode_i, cfg_decrypt_i, cfg_iv_i, key_i, key_load_i, msg_start_i,
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  core_data_i, core_ready_i, core_done_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, cfg_err_o,
    output core_start_enc_o, core_start_dec_o, core_load_key_o, core_data_o
  );

  modport master (
    output cfg_mode_i, cfg_decrypt_i, cfg_iv_i, key_i, key_load_i, msg_start_i,
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    output core_data_i, core_ready_i, core_done_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, cfg_err_o,
    input  core_start_enc_o, core_start_dec_o, core_load_key_o, core_data_o
  );
endinterface

// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - ECB/CBC/CTR block-mode sequencer and key-load arbiter for a shared AES-128 core
module aes_mode_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_OPEN,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;
  localparam logic [127:0] CTR_MASK =
    (CTR_WIDTH >= 128) ? {128{1'b1}} : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_key;
  logic [127:0] r_chain;
  logic [127:0] r_ctr;
  logic [127:0] r_blk;
  logic [127:0] r_out;
  logic [1:0]   r_mode;
  logic         r_dec;
  logic         r_last;
  logic         r_err;
  logic         w_key_go;
  logic         w_msg_go;
  logic         w_err;
  logic         w_enc;
  logic [127:0] w_core_in;
  logic [127:0] w_res;
  logic [127:0] w_ctr_next;

  // Key load wins over a simultaneous message open; anything not taken is flagged.
  assign w_key_go = (r_state == S_IDLE) & bus.key_load_i & bus.core_ready_i;
  assign w_msg_go = (r_state == S_IDLE) & ~w_key_go & bus.msg_start_i & (bus.cfg_mode_i != M_RSV);
  assign w_err    = (bus.key_load_i & ~w_key_go) | (bus.msg_start_i & ~w_msg_go);

  assign w_enc      = (r_mode == M_CTR) | ~r_dec;
  assign w_ctr_next = (r_ctr & ~CTR_MASK) | ((r_ctr + 128'd1) & CTR_MASK);

  always_comb begin
    case (r_mode)
      M_CBC:   w_core_in = r_dec ? r_blk : (r_blk ^ r_chain);
      M_CTR:   w_core_in = r_ctr;
      default: w_core_in = r_blk;
    endcase
  end

  always_comb begin
    case (r_mode)
      M_CBC:   w_res = r_dec ? (bus.core_data_i ^ r_chain) : bus.core_data_i;
      M_CTR:   w_res = bus.core_data_i ^ r_blk;
      default: w_res = bus.core_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next               = r_state;
    bus.in_ready_o       = 1'b0;
    bus.out_valid_o      = 1'b0;
    bus.out_last_o       = 1'b0;
    bus.out_data_o       = '0;
    bus.core_start_enc_o = 1'b0;
    bus.core_start_dec_o = 1'b0;
    bus.core_load_key_o  = 1'b0;
    bus.core_data_o      = '0;
    bus.busy_o           = (r_state != S_IDLE);
    bus.cfg_err_o        = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_key_go) begin
          w_next = S_KEY;
        end else if (w_msg_go) begin
          w_next = S_OPEN;
        end
      end
      S_KEY: begin
        bus.core_load_key_o = 1'b1;
        bus.core_data_o     = r_key;
        w_next              = S_IDLE;
      end
      S_OPEN: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.core_data_o = w_core_in;
        if (bus.core_ready_i) begin
          bus.core_start_enc_o = w_enc;
          bus.core_start_dec_o = ~w_enc;
          w_next               = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.core_data_o = w_core_in;
        if (bus.core_done_i) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        bus.out_valid_o = 1'b1;
        bus.out_last_o  = r_last;
        bus.out_data_o  = r_out;
        if (bus.out_ready_i) begin
          w_next = r_last ? S_IDLE : S_OPEN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_chain <= '0;
      r_ctr   <= '0;
      r_blk   <= '0;
      r_out   <= '0;
      r_mode  <= '0;
      r_dec   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_key_go) begin
        r_key <= bus.key_i;
      end
      if (w_msg_go) begin
        r_mode  <= bus.cfg_mode_i;
        r_dec   <= bus.cfg_decrypt_i;
        r_chain <= bus.cfg_iv_i;
        r_ctr   <= bus.cfg_iv_i;
      end
      if ((r_state == S_OPEN) && bus.in_valid_i) begin
        r_blk  <= bus.in_data_i;
        r_last <= bus.in_last_i;
      end
      // CBC decrypt chains on the ciphertext that went in, encrypt on what came out.
      if ((r_state == S_WAIT) && bus.core_done_i) begin
        r_out <= w_res;
        case (r_mode)
          M_CBC:   r_chain <= r_dec ? r_blk : bus.core_data_i;
          M_CTR:   r_ctr   <= w_ctr_next;
          default: ;
        endcase
      end
    end
  end

endmodule
